// File: rtl/t1s_tick.sv
// t1s_tick: divides clk to a one-cycle strobe s every CLK_FREQ_HZ/TICK_HZ clocks.
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   s         out  one-cycle tick strobe
//   tog       out  toggles on every tick
//   sec_count out  ticks since reset, wraps modulo 2^CNT_W
module t1s_tick #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             s,
  output logic             tog,
  output logic [CNT_W-1:0] sec_count
);
  // Guarded division keeps elaboration alive long enough for the check below to report.
  localparam int unsigned DIV = (TICK_HZ == 0) ? 1 : CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  if (TICK_HZ == 0 || TICK_HZ > CLK_FREQ_HZ) begin : g_bad_div
    $error("t1s_tick: TICK_HZ must be in 1..CLK_FREQ_HZ");
  end
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_q, s_d, tog_q, tog_d;
  logic [CNT_W-1:0] sec_q, sec_d;
  logic             wrap;
  always_comb begin
    wrap  = cnt_q == LAST;
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    s_d   = wrap;
    tog_d = tog_q ^ wrap;
    sec_d = sec_q + CNT_W'(wrap);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      s_q   <= 1'b0;
      tog_q <= 1'b0;
      sec_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      s_q   <= s_d;
      tog_q <= tog_d;
      sec_q <= sec_d;
    end
  end
  assign s         = s_q;
  assign tog       = tog_q;
  assign sec_count = sec_q;
endmodule

// File: tb/tb_t1s_tick.sv
// tb_t1s_tick: self-checking bench for t1s_tick across three divide configurations.
module tb_t1s_tick;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sa, ta, sb, tb_o, sc, tc;
  logic [15:0] ca, cc;
  logic [1:0]  cb;

  t1s_tick #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .s(sa), .tog(ta), .sec_count(ca));
  t1s_tick #(.CLK_FREQ_HZ(4), .TICK_HZ(1), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .s(sb), .tog(tb_o), .sec_count(cb));
  t1s_tick #(.CLK_FREQ_HZ(1), .TICK_HZ(1), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .s(sc), .tog(tc), .sec_count(cc));

  always #5 clk = ~clk;

  typedef struct {int s; int t; int c;} exp_t;
  typedef struct {int ed; int dut; int s; int t; int c;} vec_t;

  exp_t q[$];
  vec_t tbl[14];
  int   compared = 0;
  int   mismatched = 0;
  int   e = 0;
  int   rec_sa[64], rec_ta[64], rec_ca[64], rec_sb[64], rec_tb[64], rec_cb[64];

  task automatic chk(string n, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // Closed-form expectation for edge ed after release: k complete periods elapsed.
  function automatic exp_t model(int div, int w, int ed);
    exp_t r;
    int   k;
    k   = ed / div;
    r.s = (ed > 0 && ed % div == 0) ? 1 : 0;
    r.t = k % 2;
    r.c = k % (1 << w);
    return r;
  endfunction

  task automatic chk_zero(string tag);
    chk({tag, " A s"}, int'(sa), 0);
    chk({tag, " A tog"}, int'(ta), 0);
    chk({tag, " A cnt"}, int'(ca), 0);
    chk({tag, " B cnt"}, int'(cb), 0);
    chk({tag, " C s"}, int'(sc), 0);
    chk({tag, " C tog"}, int'(tc), 0);
  endtask

  task automatic step();
    exp_t x;
    e++;
    q.push_back(model(10, 16, e));
    q.push_back(model(4, 2, e));
    q.push_back(model(1, 16, e));
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk($sformatf("A s e%0d", e), int'(sa), x.s);
    chk($sformatf("A tog e%0d", e), int'(ta), x.t);
    chk($sformatf("A cnt e%0d", e), int'(ca), x.c);
    x = q.pop_front();
    chk($sformatf("B s e%0d", e), int'(sb), x.s);
    chk($sformatf("B tog e%0d", e), int'(tb_o), x.t);
    chk($sformatf("B cnt e%0d", e), int'(cb), x.c);
    x = q.pop_front();
    chk($sformatf("C s e%0d", e), int'(sc), x.s);
    chk($sformatf("C tog e%0d", e), int'(tc), x.t);
    chk($sformatf("C cnt e%0d", e), int'(cc), x.c);
    if (e < 64) begin
      rec_sa[e] = int'(sa); rec_ta[e] = int'(ta); rec_ca[e] = int'(ca);
      rec_sb[e] = int'(sb); rec_tb[e] = int'(tb_o); rec_cb[e] = int'(cb);
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{9, 0, 0, 0, 0};
    tbl[1]  = '{10, 0, 1, 1, 1};
    tbl[2]  = '{11, 0, 0, 1, 1};
    tbl[3]  = '{20, 0, 1, 0, 2};
    tbl[4]  = '{21, 0, 0, 0, 2};
    tbl[5]  = '{30, 0, 1, 1, 3};
    tbl[6]  = '{31, 0, 0, 1, 3};
    tbl[7]  = '{35, 0, 0, 1, 3};
    tbl[8]  = '{4, 1, 1, 1, 1};
    tbl[9]  = '{8, 1, 1, 0, 2};
    tbl[10] = '{12, 1, 1, 1, 3};
    tbl[11] = '{16, 1, 1, 0, 0};
    tbl[12] = '{17, 1, 0, 0, 0};
    tbl[13] = '{20, 1, 1, 1, 1};

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk_zero($sformatf("reset cyc%0d", i));
    end

    release_rst();
    for (int i = 0; i < 35; i++) step();
    foreach (tbl[i]) begin
      if (tbl[i].dut == 0) begin
        chk($sformatf("tbl A s e%0d", tbl[i].ed), rec_sa[tbl[i].ed], tbl[i].s);
        chk($sformatf("tbl A tog e%0d", tbl[i].ed), rec_ta[tbl[i].ed], tbl[i].t);
        chk($sformatf("tbl A cnt e%0d", tbl[i].ed), rec_ca[tbl[i].ed], tbl[i].c);
      end else begin
        chk($sformatf("tbl B s e%0d", tbl[i].ed), rec_sb[tbl[i].ed], tbl[i].s);
        chk($sformatf("tbl B tog e%0d", tbl[i].ed), rec_tb[tbl[i].ed], tbl[i].t);
        chk($sformatf("tbl B cnt e%0d", tbl[i].ed), rec_cb[tbl[i].ed], tbl[i].c);
      end
    end

    rst_n = 1'b0;
    release_rst();
    for (int i = 0; i < 15; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset async");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk_zero($sformatf("midreset hold%0d", i));
    end
    release_rst();
    for (int i = 0; i < 10; i++) step();

    chk("pulse before reset A s", int'(sa), 1);
    rst_n = 1'b0;
    #1;
    chk("pulse reset A s", int'(sa), 0);
    chk("pulse reset A cnt", int'(ca), 0);
    chk("pulse reset A tog", int'(ta), 0);
    chk("pulse reset C s", int'(sc), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
